branch_unit: RTL
================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal values 2 and 4).
REQ-002 SHALL have parameter CNT_W, default 16, meaning taken-counter width.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request this cycle.
REQ-007 funct3  input  3  RISC-V branch funct3.
REQ-008 pc  input  32  branch instruction address.
REQ-009 imm  input  32  sign-extended B-immediate.
REQ-010 N, Z, C, V  input  1 each  ALU flags of the subtraction rs1-rs2; C is carry-out of A+~B+1, so C=1 means A>=B unsigned.
REQ-011 flush  input  1  synchronous discard of all buffered results.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_taken, out_illegal, out_misaligned  output  1 each  result flags.
REQ-015 out_target  output  32  next PC.
REQ-016 taken_cnt  output  CNT_W  saturating count of taken branches delivered.

Function
REQ-017 Request SHALL be accepted when in_valid && in_ready at a rising edge.
REQ-018 Conditions SHALL be: 000 BEQ=Z; 001 BNE=!Z; 100 BLT=N^V; 101 BGE=!(N^V); 110 BLTU=!C; 111 BGEU=C.
REQ-019 funct3 010/011 SHALL produce out_illegal=1, out_taken=0, out_target=pc+4.
REQ-020 out_target SHALL be pc+imm when taken, else pc+4, modulo 2^32 (wrap-around, no carry flag).
REQ-021 out_misaligned SHALL be 1 only when taken and (pc+imm)[1:0]!=0.
REQ-022 Results SHALL be computed at acceptance and written into a DEPTH-entry FIFO; minimum latency is one cycle (accept at edge n, out_valid high after edge n).
REQ-023 Results SHALL leave in acceptance order; out_* SHALL be stable while out_valid && !out_ready.
REQ-024 in_ready SHALL be 1 when occupancy < DEPTH, or occupancy == DEPTH and out_ready is 1 (simultaneous pop frees the slot); in_ready SHALL be 0 during the cycle flush is high.
REQ-025 Simultaneous push and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-026 flush SHALL empty the FIFO at the next edge, overriding any push or pop that cycle; taken_cnt is not modified by flush.
REQ-027 taken_cnt SHALL increment on each pop with out_taken=1 and hold at 2^CNT_W-1.
REQ-028 out_valid SHALL be 0 when FIFO empty; out_* data then SHALL read 0.

Reset
REQ-029 On rst_n low, immediately and independent of clk: occupancy, pointers, taken_cnt = 0; out_valid=0; in_ready=0.
REQ-030 in_ready SHALL rise at the first edge after rst_n deasserts; reset mid-operation SHALL discard all buffered results with no partial output.

Structure
REQ-031 Shared package SHALL hold funct3 encoding constants (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the result-record type {taken, illegal, misaligned, target}.
REQ-032 Condition/target evaluation SHALL be one combinational sub-module branch_cond; FIFO and counter logic live in branch_unit.

Verification
REQ-033 BEQ, Z=1, pc=0x100, imm=0x20, out_ready=1 -> next cycle out_valid=1, taken=1, target=0x120, taken_cnt=1 after pop.
REQ-034 BLT with N=1,V=1 (not less) pc=0x200 -> taken=0, target=0x204; BLTU with C=0 -> taken=1.
REQ-035 funct3=010 -> illegal=1, taken=0, target=pc+4; pc=0xFFFFFFFC not taken -> target=0x00000000.
REQ-036 out_ready=0, push 3 requests -> in_ready=0 after 2; raise out_ready -> in_ready=1 same cycle, order preserved.
REQ-037 BEQ taken, pc=0x100, imm=0x6 -> misaligned=1; full FIFO then flush=1 with in_valid=1 -> next cycle out_valid=0, nothing accepted.
REQ-038 Assert rst_n low asynchronously between edges with 2 entries buffered -> out_valid=0 immediately, taken_cnt=0.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch resolution unit: funct3 encodings and
// the result record carried through the output buffer.
package branch_unit_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct packed {
        logic        taken;
        logic        illegal;
        logic        misaligned;
        logic [31:0] target;
    } br_result_t;

    function automatic logic is_branch_f3(input logic [2:0] f3);
        return (f3 == BEQ) || (f3 == BNE) || (f3 == BLT) ||
               (f3 == BGE) || (f3 == BLTU) || (f3 == BGEU);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch evaluation: condition from ALU flags of rs1-rs2,
// next-PC selection and target alignment check.
module branch_cond
    import branch_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    input  logic        V,
    output br_result_t  result
);

    logic        cond;
    logic        legal;
    logic [31:0] jump_target;
    logic [31:0] seq_target;

    assign legal       = is_branch_f3(funct3);
    assign jump_target = pc + imm;
    assign seq_target  = pc + 32'd4;

    // C is the carry of A+~B+1, so C=1 means rs1 >= rs2 unsigned.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            BEQ:     cond = Z;
            BNE:     cond = !Z;
            BLT:     cond = N ^ V;
            BGE:     cond = !(N ^ V);
            BLTU:    cond = !C;
            BGEU:    cond = C;
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        result            = '0;
        result.taken      = cond && legal;
        result.illegal    = !legal;
        result.target     = result.taken ? jump_target : seq_target;
        result.misaligned = result.taken && (jump_target[1:0] != 2'b00);
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution unit: evaluates a branch at acceptance and buffers the
// result in a small in-order FIFO; counts taken branches as they leave.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [31:0]      pc,
    input  logic [31:0]      imm,
    input  logic             N,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_illegal,
    output logic             out_misaligned,
    output logic [31:0]      out_target,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    br_result_t       mem [DEPTH];
    br_result_t       new_res;
    br_result_t       head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             ready_en;
    logic             push;
    logic             pop;

    branch_cond u_cond (
        .funct3 (funct3),
        .pc     (pc),
        .imm    (imm),
        .N      (N),
        .Z      (Z),
        .C      (C),
        .V      (V),
        .result (new_res)
    );

    // ready_en keeps in_ready low until the first edge after reset release.
    assign in_ready  = ready_en && !flush && ((count != FULL) || out_ready);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;
    assign head      = out_valid ? mem[rd_ptr] : '0;

    assign out_taken      = head.taken;
    assign out_illegal    = head.illegal;
    assign out_misaligned = head.misaligned;
    assign out_target     = head.target;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= new_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            taken_cnt <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W + 1)'(1);
                    2'b01:   count <= count - (PTR_W + 1)'(1);
                    default: ;
                endcase
            end
            if (pop && head.taken && (taken_cnt != '1)) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end

endmodule
